mmc3_irq_counter: RTL and testbench
===================================

MMC3_IRQ_COUNTER -- requirements
Module: mmc3_irq_counter

Interface
REQ-001 SHALL have parameter A12_LOW_MIN, default 3, the minimum number of consecutive m2 cycles with A12 low before a rising edge counts as a clock.
REQ-002 SHALL have port m2, input, 1 bit: the single clock (CPU M2); all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ppu_a12, input, 1 bit: raw PPU address bit 12, asynchronous to m2.
REQ-005 SHALL have port reg_we, input, 1 bit: one-cycle register write strobe from the CPU decode.
REQ-006 SHALL have port reg_sel, input, 2 bits: 0=latch ($C000), 1=reload ($C001), 2=disable/ack ($E000), 3=enable ($E001).
REQ-007 SHALL have port reg_data, input, 8 bits: write data; used only when reg_sel=0.
REQ-008 SHALL have port irq, output, 1 bit: active-high IRQ request; the top level inverts/open-drains it.
REQ-009 SHALL have port counter, output, 8 bits: current counter value, for debug readback.

Function
REQ-010 SHALL synchronise ppu_a12 through two flip-flops (s1, s2) and keep a third history flop s3; a rising edge is s2=1 and s3=0.
REQ-011 SHALL keep low_cnt (width fits A12_LOW_MIN): cleared while s2=1, incremented while s2=0, saturating at A12_LOW_MIN.
REQ-012 SHALL accept a rising edge as a clock only when low_cnt==A12_LOW_MIN in that cycle; other edges SHALL be ignored (glitch/sprite-fetch filter).
REQ-013 SHALL, on an accepted clock with counter==0 or reload_pending=1: load counter from latch and clear reload_pending; otherwise decrement counter by 1 (8-bit, no wrap past 0 because 0 always reloads).
REQ-014 SHALL, in default mode, set irq when the post-update counter value is 0 and enabled=1.
REQ-015 SHALL apply latency of exactly 2 m2 edges: an A12 rise captured by s1 at edge N updates counter and irq at edge N+2.
REQ-016 SHALL on write sel 0: latch<=reg_data; on write sel 1: counter<=0, reload_pending<=1; on write sel 2: enabled<=0, irq<=0; on write sel 3: enabled<=1, irq unchanged.
REQ-017 SHALL, when a write and an accepted clock occur in the same cycle, compute the clock action from pre-write state, then let the write override the affected fields: sel 1 forces counter=0 and reload_pending=1; sel 2 forces irq=0; sel 0 updates the latch only, so a same-cycle reload uses the old latch.
REQ-018 SHALL hold irq set until a sel-2 write or reset; further clocks SHALL NOT clear it.
REQ-019 SHALL, with latch=0, reload to 0 on every accepted clock, and in default mode SHALL assert irq on each such clock while enabled.

Reset
REQ-020 SHALL, when reset=1 at a rising m2 edge, clear s1, s2, s3, low_cnt, counter, latch, reload_pending, enabled and irq to 0; a reset during counting SHALL abandon the count.
REQ-021 SHALL have every output 0 in the cycle after reset; because low_cnt starts at 0, A12 must be low A12_LOW_MIN cycles before the first clock is accepted.

Configuration
REQ-022 SHALL provide macro MMC3_IRQ_ALT_EN; when defined, irq SHALL set only when an accepted clock decrements the counter from 1 to 0, and a reload to 0 SHALL NOT set it ("old" MMC3 behaviour); when undefined, REQ-014 applies.

Verification
REQ-023 SHALL cover: latch=3, reload, enable, then 4 clean A12 pulses (low 4 cycles each) -> counter sequence 3,2,1,0, and irq=1 exactly 2 edges after the 4th rise is captured.
REQ-024 SHALL cover: A12 low only 2 cycles before a rise with A12_LOW_MIN=3 -> counter unchanged, irq stays 0.
REQ-025 SHALL cover: irq set, then sel-2 write in the same cycle as an accepted clock that reaches 0 -> irq=0 afterwards; a sel-3 write leaves irq 0 until the next zero.
REQ-026 SHALL cover: latch=0, enabled -> irq on the first accepted clock in default mode, and never with MMC3_IRQ_ALT_EN defined.
REQ-027 SHALL cover: sel-1 write coincident with an accepted clock at counter=5, latch=9 -> counter=0 and reload_pending=1 afterwards, and the next clock loads 9.
REQ-028 SHALL cover: reset asserted mid-count (counter=2, irq=1) -> all outputs 0 next cycle, and the first A12 rise within 3 cycles after reset is ignored.

Source files
------------

// File: rtl/mmc3_irq_counter.sv
// mmc3_irq_counter: MMC3-style scanline IRQ counter clocked by filtered PPU A12 rises.
// Optional build macro: MMC3_IRQ_ALT_EN selects the "old" MMC3 IRQ behaviour
// (IRQ only on a 1->0 decrement, never on a reload to 0).
// Ports:
//   m2        - CPU M2, the only clock; all state updates on its rising edge
//   reset     - synchronous active-high reset
//   ppu_a12   - raw PPU address bit 12, asynchronous to m2
//   reg_we    - one-cycle register write strobe
//   reg_sel   - 0=latch, 1=reload, 2=disable/ack, 3=enable
//   reg_data  - write data, used only for the latch register
//   irq       - active-high IRQ request
//   counter   - current counter value for debug readback
module mmc3_irq_counter #(
  parameter int unsigned A12_LOW_MIN = 3
) (
  input  logic       m2,
  input  logic       reset,
  input  logic       ppu_a12,
  input  logic       reg_we,
  input  logic [1:0] reg_sel,
  input  logic [7:0] reg_data,
  output logic       irq,
  output logic [7:0] counter
);

  localparam int unsigned LOW_W = (A12_LOW_MIN < 1) ? 1 : $clog2(A12_LOW_MIN + 1);
  localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(A12_LOW_MIN);

  logic             s1, s2, s3;
  logic [LOW_W-1:0] low_cnt;
  logic [7:0]       latch;
  logic             reload_pending;
  logic             enabled;

  logic             accept;
  logic             reload;
  logic             irq_set;
  logic [LOW_W-1:0] low_cnt_next;
  logic [7:0]       counter_next;
  logic [7:0]       latch_next;
  logic             reload_pending_next;
  logic             enabled_next;
  logic             irq_next;

  // A12 low-time filter: only a rise preceded by enough low cycles clocks the counter
  always_comb begin
    low_cnt_next = low_cnt;
    if (s2) begin
      low_cnt_next = '0;
    end else if (low_cnt != LOW_MAX) begin
      low_cnt_next = low_cnt + LOW_W'(1);
    end
  end

  assign accept = s2 && !s3 && (low_cnt == LOW_MAX);
  assign reload = (counter == 8'd0) || reload_pending;

  // Clock action first from pre-write state, then register writes override their fields
  always_comb begin
    counter_next        = counter;
    latch_next          = latch;
    reload_pending_next = reload_pending;
    enabled_next        = enabled;
    irq_set             = 1'b0;

    if (accept) begin
      if (reload) begin
        counter_next        = latch;
        reload_pending_next = 1'b0;
      end else begin
        counter_next = counter - 8'd1;
      end
`ifdef MMC3_IRQ_ALT_EN
      irq_set = enabled && !reload && (counter == 8'd1);
`else
      irq_set = enabled && (counter_next == 8'd0);
`endif
    end

    irq_next = irq | irq_set;

    if (reg_we) begin
      case (reg_sel)
        2'd0: latch_next = reg_data;
        2'd1: begin
          counter_next        = 8'd0;
          reload_pending_next = 1'b1;
        end
        2'd2: begin
          enabled_next = 1'b0;
          irq_next     = 1'b0;
        end
        default: enabled_next = 1'b1;
      endcase
    end
  end

  // State registers, including the A12 synchroniser and edge-history flop
  always_ff @(posedge m2) begin
    if (reset) begin
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      low_cnt        <= '0;
      counter        <= 8'd0;
      latch          <= 8'd0;
      reload_pending <= 1'b0;
      enabled        <= 1'b0;
      irq            <= 1'b0;
    end else begin
      s1             <= ppu_a12;
      s2             <= s1;
      s3             <= s2;
      low_cnt        <= low_cnt_next;
      counter        <= counter_next;
      latch          <= latch_next;
      reload_pending <= reload_pending_next;
      enabled        <= enabled_next;
      irq            <= irq_next;
    end
  end

endmodule

// File: tb/tb_mmc3_irq_counter.sv
// Directed testbench for mmc3_irq_counter (A12_LOW_MIN = 3).
// Honours MMC3_IRQ_ALT_EN for the expected IRQ values of the latch=0 case.
module tb_mmc3_irq_counter;

  logic       m2 = 1'b0;
  logic       reset;
  logic       ppu_a12;
  logic       reg_we;
  logic [1:0] reg_sel;
  logic [7:0] reg_data;
  logic       irq;
  logic [7:0] counter;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MMC3_IRQ_ALT_EN
  localparam logic [7:0] IRQ_ON_ZERO_RELOAD = 8'd0;
`else
  localparam logic [7:0] IRQ_ON_ZERO_RELOAD = 8'd1;
`endif

  mmc3_irq_counter #(.A12_LOW_MIN(3)) dut (
    .m2       (m2),
    .reset    (reset),
    .ppu_a12  (ppu_a12),
    .reg_we   (reg_we),
    .reg_sel  (reg_sel),
    .reg_data (reg_data),
    .irq      (irq),
    .counter  (counter)
  );

  always #5 m2 = ~m2;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge m2);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] data);
    reg_we   = 1'b1;
    reg_sel  = sel;
    reg_data = data;
    tick(1);
    reg_we   = 1'b0;
  endtask

  // A12 low for 'low' edges, then high for 'high' edges; the counter moves on the 3rd high edge
  task automatic a12_pulse(input int low, input int high);
    ppu_a12 = 1'b0;
    tick(low);
    ppu_a12 = 1'b1;
    tick(high);
  endtask

  initial begin
    reset    = 1'b1;
    ppu_a12  = 1'b0;
    reg_we   = 1'b0;
    reg_sel  = 2'd0;
    reg_data = 8'd0;
    tick(2);
    check("reset_irq", 8'(irq), 8'd0);
    check("reset_counter", counter, 8'd0);
    reset = 1'b0;

    // latch=3, reload, enable, four clean pulses: 3,2,1,0
    wr(2'd0, 8'd3);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    a12_pulse(4, 3);
    check("seq_load3", counter, 8'd3);
    a12_pulse(4, 3);
    check("seq_dec2", counter, 8'd2);
    a12_pulse(4, 3);
    check("seq_dec1", counter, 8'd1);
    check("seq_irq_before_zero", 8'(irq), 8'd0);
    a12_pulse(4, 2);
    check("latency_counter_early", counter, 8'd1);
    check("latency_irq_early", 8'(irq), 8'd0);
    tick(1);
    check("seq_zero", counter, 8'd0);
    check("seq_irq", 8'(irq), 8'd1);

    // ack, then a rise after only 2 low cycles is filtered out
    wr(2'd2, 8'd0);
    check("ack_irq", 8'(irq), 8'd0);
    a12_pulse(2, 3);
    check("short_low_counter", counter, 8'd0);
    check("short_low_irq", 8'(irq), 8'd0);
    a12_pulse(4, 3);
    check("filter_recovers", counter, 8'd3);
    check("disabled_no_irq", 8'(irq), 8'd0);

    // irq held across later clocks; ack coincident with a clock reaching 0
    wr(2'd3, 8'd0);
    wr(2'd0, 8'd1);
    a12_pulse(4, 3);
    a12_pulse(4, 3);
    check("dec_to_1", counter, 8'd1);
    a12_pulse(4, 3);
    check("reach_zero_irq", 8'(irq), 8'd1);
    a12_pulse(4, 3);
    check("hold_reload_counter", counter, 8'd1);
    check("hold_irq", 8'(irq), 8'd1);
    a12_pulse(4, 2);
    wr(2'd2, 8'd0);
    check("ack_coincident_counter", counter, 8'd0);
    check("ack_coincident_irq", 8'(irq), 8'd0);
    wr(2'd3, 8'd0);
    check("enable_keeps_irq_low", 8'(irq), 8'd0);
    a12_pulse(4, 3);
    check("reload_no_irq_counter", counter, 8'd1);
    check("reload_no_irq", 8'(irq), 8'd0);
    a12_pulse(4, 3);
    check("next_zero_irq", 8'(irq), 8'd1);

    // reload write coincident with a clock at counter=5, latch=9
    wr(2'd0, 8'd5);
    a12_pulse(4, 3);
    check("load5", counter, 8'd5);
    wr(2'd0, 8'd9);
    wr(2'd2, 8'd0);
    wr(2'd3, 8'd0);
    a12_pulse(4, 2);
    wr(2'd1, 8'd0);
    check("reload_coincident_counter", counter, 8'd0);
    check("reload_coincident_irq", 8'(irq), 8'd0);
    a12_pulse(4, 3);
    check("reload_loads9", counter, 8'd9);
    check("reload_loads9_irq", 8'(irq), 8'd0);

    // latch=0: irq on every clock in default mode, never in alt mode
    wr(2'd0, 8'd0);
    wr(2'd1, 8'd0);
    a12_pulse(4, 3);
    check("latch0_counter", counter, 8'd0);
    check("latch0_irq_first", 8'(irq), IRQ_ON_ZERO_RELOAD);
    a12_pulse(4, 3);
    check("latch0_irq_second", 8'(irq), IRQ_ON_ZERO_RELOAD);

    // reset mid-count with counter=2, irq=1
    wr(2'd2, 8'd0);
    wr(2'd3, 8'd0);
    wr(2'd0, 8'd1);
    a12_pulse(4, 3);
    a12_pulse(4, 3);
    wr(2'd0, 8'd3);
    a12_pulse(4, 3);
    a12_pulse(4, 3);
    check("pre_reset_counter", counter, 8'd2);
    check("pre_reset_irq", 8'(irq), 8'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("post_reset_counter", counter, 8'd0);
    check("post_reset_irq", 8'(irq), 8'd0);
    // A12 stays high; its rise reaches s2 too soon after reset to be accepted
    reg_we   = 1'b1;
    reg_sel  = 2'd0;
    reg_data = 8'd7;
    tick(1);
    reg_we   = 1'b0;
    tick(2);
    check("early_rise_ignored", counter, 8'd0);
    tick(2);
    check("early_rise_still_ignored", counter, 8'd0);
    a12_pulse(4, 3);
    check("post_reset_clock", counter, 8'd7);
    check("post_reset_disabled", 8'(irq), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
